// File: rtl/grf_wb_arbiter.sv
// -----------------------------------------------------------------------------
// grf_wb_arbiter
//
// Shares the register file's single write port between the main pipeline
// write-back stage and an auxiliary long-latency unit. The pipeline always
// wins. Auxiliary writes go through a small in-order queue and drain into
// write-port cycles that the pipeline leaves idle.
//
// Ports
//   clk, reset             clock, synchronous active-high reset
//   pipe_we/a3/wd/pc       pipeline write request for this cycle
//   aux_valid/a3/wd/pc     auxiliary write offer; aux_ready = queue not full
//   grf_we/a3/wd/pc        registered register-file write port (1-cycle latency)
//   q1_a/q2_a              hazard query addresses
//   q1_busy/q2_busy        query register still has a write pending
//   stall_req              queue head starved; upstream should hold pipe_we
// -----------------------------------------------------------------------------
module grf_wb_arbiter #(
    parameter int DEPTH    = 2,
    parameter int MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        pipe_we,
    input  logic [4:0]  pipe_a3,
    input  logic [31:0] pipe_wd,
    input  logic [31:0] pipe_pc,

    input  logic        aux_valid,
    output logic        aux_ready,
    input  logic [4:0]  aux_a3,
    input  logic [31:0] aux_wd,
    input  logic [31:0] aux_pc,

    output logic        grf_we,
    output logic [4:0]  grf_a3,
    output logic [31:0] grf_wd,
    output logic [31:0] grf_pc,

    input  logic [4:0]  q1_a,
    input  logic [4:0]  q2_a,
    output logic        q1_busy,
    output logic        q2_busy,

    output logic        stall_req
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int WW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

    localparam logic [AW:0]   C_FULL = (AW + 1)'(DEPTH);
    localparam logic [WW-1:0] C_MAXW = WW'(MAX_WAIT);

    // ------------------------------------------------------------------
    // Queue storage
    // ------------------------------------------------------------------
    logic [4:0]  r_q_a3   [DEPTH];
    logic [31:0] r_q_wd   [DEPTH];
    logic [31:0] r_q_pc   [DEPTH];
    logic        r_q_live [DEPTH];

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic [WW-1:0] r_wait;

    logic        r_grf_we;
    logic [4:0]  r_grf_a3;
    logic [31:0] r_grf_wd;
    logic [31:0] r_grf_pc;

    // ------------------------------------------------------------------
    // Selection
    // ------------------------------------------------------------------
    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_pipe_sel;
    logic w_head_wr;

    assign w_empty    = (r_count == '0);
    assign aux_ready  = (r_count != C_FULL);
    assign w_push     = aux_valid && aux_ready;
    assign w_pipe_sel = pipe_we && (pipe_a3 != 5'd0);

    // A pipeline request to r0 still owns the slot, so the queue only
    // drains when pipe_we is low.
    assign w_pop      = !pipe_we && !w_empty;

    // A popped head only reaches the register file if it survived WAW
    // kills and does not target r0.
    assign w_head_wr  = w_pop && r_q_live[r_rd_ptr] && (r_q_a3[r_rd_ptr] != 5'd0);

    // ------------------------------------------------------------------
    // Write-port output register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_grf_we <= 1'b0;
            r_grf_a3 <= 5'd0;
            r_grf_wd <= 32'd0;
            r_grf_pc <= 32'd0;
        end else if (w_pipe_sel) begin
            r_grf_we <= 1'b1;
            r_grf_a3 <= pipe_a3;
            r_grf_wd <= pipe_wd;
            r_grf_pc <= pipe_pc;
        end else if (w_head_wr) begin
            r_grf_we <= 1'b1;
            r_grf_a3 <= r_q_a3[r_rd_ptr];
            r_grf_wd <= r_q_wd[r_rd_ptr];
            r_grf_pc <= r_q_pc[r_rd_ptr];
        end else begin
            // Nothing selected: drop the enable, hold address/data/PC.
            r_grf_we <= 1'b0;
        end
    end

    assign grf_we = r_grf_we;
    assign grf_a3 = r_grf_a3;
    assign grf_wd = r_grf_wd;
    assign grf_pc = r_grf_pc;

    // ------------------------------------------------------------------
    // Queue update: WAW kill, pop, push
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_q_a3[i]   <= 5'd0;
                r_q_wd[i]   <= 32'd0;
                r_q_pc[i]   <= 32'd0;
                r_q_live[i] <= 1'b0;
            end
        end else begin
            // An older queued write to the same register would overwrite the
            // pipeline's newer value when it drains, so it is killed here.
            if (w_pipe_sel) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (r_q_live[i] && (r_q_a3[i] == pipe_a3))
                        r_q_live[i] <= 1'b0;
                end
            end
            if (w_pop)
                r_q_live[r_rd_ptr] <= 1'b0;
            // Push comes last so an entry accepted at the same edge as a
            // matching pipeline write is treated as younger and stays live.
            // wr_ptr never aliases a stored entry because a full queue
            // refuses pushes.
            if (w_push) begin
                r_q_a3[r_wr_ptr]   <= aux_a3;
                r_q_wd[r_wr_ptr]   <= aux_wd;
                r_q_pc[r_wr_ptr]   <= aux_pc;
                r_q_live[r_wr_ptr] <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Pointers and occupancy
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Starvation counter: counts edges where a non-empty queue's head was
    // blocked; saturates so a pipeline that ignores stall_req cannot wrap it.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wait <= '0;
        end else if (w_empty || w_pop) begin
            r_wait <= '0;
        end else if (r_wait < C_MAXW) begin
            r_wait <= r_wait + 1'b1;
        end
    end

    assign stall_req = (r_wait >= C_MAXW) && !w_empty;

    // ------------------------------------------------------------------
    // Hazard lookups. Killed entries never write, so only live entries and
    // the write currently on the port count as pending.
    // ------------------------------------------------------------------
    logic w_q1_hit;
    logic w_q2_hit;

    always_comb begin
        w_q1_hit = 1'b0;
        w_q2_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_q_live[i] && (r_q_a3[i] == q1_a)) w_q1_hit = 1'b1;
            if (r_q_live[i] && (r_q_a3[i] == q2_a)) w_q2_hit = 1'b1;
        end
    end

    assign q1_busy = (q1_a != 5'd0) && (w_q1_hit || (r_grf_we && (r_grf_a3 == q1_a)));
    assign q2_busy = (q2_a != 5'd0) && (w_q2_hit || (r_grf_we && (r_grf_a3 == q2_a)));

endmodule

// File: tb/tb_grf_wb_arbiter.sv
module tb_grf_wb_arbiter;

    localparam int DEPTH    = 2;
    localparam int MAX_WAIT = 4;

    logic        clk;
    logic        reset;
    logic        pipe_we;
    logic [4:0]  pipe_a3;
    logic [31:0] pipe_wd;
    logic [31:0] pipe_pc;
    logic        aux_valid;
    logic        aux_ready;
    logic [4:0]  aux_a3;
    logic [31:0] aux_wd;
    logic [31:0] aux_pc;
    logic        grf_we;
    logic [4:0]  grf_a3;
    logic [31:0] grf_wd;
    logic [31:0] grf_pc;
    logic [4:0]  q1_a;
    logic [4:0]  q2_a;
    logic        q1_busy;
    logic        q2_busy;
    logic        stall_req;

    grf_wb_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .reset(reset),
        .pipe_we(pipe_we), .pipe_a3(pipe_a3), .pipe_wd(pipe_wd), .pipe_pc(pipe_pc),
        .aux_valid(aux_valid), .aux_ready(aux_ready),
        .aux_a3(aux_a3), .aux_wd(aux_wd), .aux_pc(aux_pc),
        .grf_we(grf_we), .grf_a3(grf_a3), .grf_wd(grf_wd), .grf_pc(grf_pc),
        .q1_a(q1_a), .q2_a(q2_a), .q1_busy(q1_busy), .q2_busy(q2_busy),
        .stall_req(stall_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: a plain list of pending aux writes plus the
    // write-port state, advanced one edge at a time.
    // ------------------------------------------------------------------
    typedef struct {
        logic [4:0]  a3;
        logic [31:0] wd;
        logic [31:0] pc;
        bit          live;
    } ent_t;

    typedef struct packed {
        logic        we;
        logic [4:0]  a3;
        logic [31:0] wd;
        logic [31:0] pc;
    } out_t;

    ent_t mq[$];
    int   mwait;
    out_t mout;
    bit   mvalid;
    out_t expq[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit m_busy(input logic [4:0] q);
        if (q == 5'd0) return 1'b0;
        if (mout.we && mout.a3 == q) return 1'b1;
        foreach (mq[i]) if (mq[i].live && mq[i].a3 == q) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_stall();
        return (mwait >= MAX_WAIT) && (mq.size() > 0);
    endfunction

    // One clock cycle: drive at the falling edge, check the combinational
    // outputs against the current model state, then advance the model and
    // queue the register-port value expected after the next rising edge.
    task automatic cyc(input bit rst,
                       input bit pwe, input logic [4:0] pa3, input logic [31:0] pwd, input logic [31:0] ppc,
                       input bit av, input logic [4:0] aa3, input logic [31:0] awd, input logic [31:0] apc,
                       input logic [4:0] qa1, input logic [4:0] qa2);
        bit   ready;
        bit   pop;
        bit   was_empty;
        ent_t h;
        ent_t n;
        @(negedge clk);
        reset     = rst;
        pipe_we   = pwe;  pipe_a3 = pa3;  pipe_wd = pwd;  pipe_pc = ppc;
        aux_valid = av;   aux_a3  = aa3;  aux_wd  = awd;  aux_pc  = apc;
        q1_a      = qa1;  q2_a    = qa2;
        #1;
        if (mvalid) begin
            chk("aux_ready", 64'(aux_ready), 64'(mq.size() < DEPTH));
            chk("stall_req", 64'(stall_req), 64'(m_stall()));
            chk("q1_busy",   64'(q1_busy),   64'(m_busy(qa1)));
            chk("q2_busy",   64'(q2_busy),   64'(m_busy(qa2)));
        end
        if (rst) begin
            mq.delete();
            mwait  = 0;
            mout   = '0;
            mvalid = 1'b1;
        end else if (mvalid) begin
            ready     = (mq.size() < DEPTH);
            was_empty = (mq.size() == 0);
            pop       = !pwe && !was_empty;
            if (pwe && pa3 != 5'd0) begin
                mout.we = 1'b1; mout.a3 = pa3; mout.wd = pwd; mout.pc = ppc;
                for (int i = 0; i < mq.size(); i++)
                    if (mq[i].a3 == pa3) mq[i].live = 1'b0;
            end else if (pop) begin
                h = mq.pop_front();
                if (h.live && h.a3 != 5'd0) begin
                    mout.we = 1'b1; mout.a3 = h.a3; mout.wd = h.wd; mout.pc = h.pc;
                end else begin
                    mout.we = 1'b0;
                end
            end else begin
                mout.we = 1'b0;
            end
            if (av && ready) begin
                n.a3 = aa3; n.wd = awd; n.pc = apc; n.live = 1'b1;
                mq.push_back(n);
            end
            if (was_empty || pop) mwait = 0;
            else if (mwait < MAX_WAIT) mwait++;
        end
        if (mvalid) expq.push_back(mout);
    endtask

    task automatic idle(input logic [4:0] qa1, input logic [4:0] qa2);
        cyc(0, 0, 5'd0, 32'd0, 32'd0, 0, 5'd0, 32'd0, 32'd0, qa1, qa2);
    endtask

    // Monitor: compares the write port after every rising edge.
    initial begin
        out_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("grf_we", 64'(grf_we), 64'(e.we));
                chk("grf_a3", 64'(grf_a3), 64'(e.a3));
                chk("grf_wd", 64'(grf_wd), 64'(e.wd));
                chk("grf_pc", 64'(grf_pc), 64'(e.pc));
            end
        end
    end

    initial begin
        int pct;
        bit pwe;
        reset = 1'b1; pipe_we = 0; pipe_a3 = 0; pipe_wd = 0; pipe_pc = 0;
        aux_valid = 0; aux_a3 = 0; aux_wd = 0; aux_pc = 0; q1_a = 0; q2_a = 0;
        mvalid = 1'b0; mwait = 0; mout = '0;

        cyc(1, 0, 5'd0, 32'd0, 32'd0, 0, 5'd0, 32'd0, 32'd0, 5'd0, 5'd0);
        cyc(1, 0, 5'd0, 32'd0, 32'd0, 0, 5'd0, 32'd0, 32'd0, 5'd5, 5'd0);

        // Basic aux write, two-edge latency.
        cyc(0, 0, 5'd0, 32'd0, 32'd0, 1, 5'd5, 32'h1234, 32'h100, 5'd5, 5'd0);
        idle(5'd5, 5'd0);
        idle(5'd5, 5'd0);
        idle(5'd5, 5'd0);

        // Pipeline hogs the port; queue fills and head starves.
        for (int i = 0; i < 8; i++)
            cyc(0, 1, 5'd3, 32'h300 + i, 32'h200 + 4 * i,
                i < 3, (i == 0) ? 5'd7 : 5'd8, 32'h70 + i, 32'h400 + i, 5'd7, 5'd8);
        idle(5'd7, 5'd8);
        idle(5'd7, 5'd8);
        idle(5'd7, 5'd8);

        // WAW kill of queued a3=9.
        cyc(0, 1, 5'd3, 32'h33, 32'h500, 1, 5'd9, 32'hAA, 32'h504, 5'd9, 5'd3);
        cyc(0, 1, 5'd9, 32'hBB, 32'h508, 0, 5'd0, 32'd0, 32'd0, 5'd9, 5'd0);
        idle(5'd9, 5'd0);
        idle(5'd9, 5'd0);
        idle(5'd9, 5'd0);

        // Same-edge pipe write and aux accept to a3=4.
        cyc(0, 1, 5'd4, 32'h44, 32'h600, 1, 5'd4, 32'h45, 32'h604, 5'd4, 5'd0);
        idle(5'd4, 5'd0);
        idle(5'd4, 5'd0);
        idle(5'd4, 5'd0);

        // r0 targets never write.
        cyc(0, 0, 5'd0, 32'd0, 32'd0, 1, 5'd0, 32'hDEAD, 32'h700, 5'd0, 5'd0);
        cyc(0, 1, 5'd0, 32'hBEEF, 32'h704, 0, 5'd0, 32'd0, 32'd0, 5'd0, 5'd0);
        idle(5'd0, 5'd0);
        idle(5'd0, 5'd0);

        // Reset while full and stalled.
        for (int i = 0; i < 7; i++)
            cyc(0, 1, 5'd2, 32'h20 + i, 32'h800 + i, i < 2, 5'd10 + 5'(i), 32'hC0 + i, 32'h900 + i, 5'd10, 5'd11);
        cyc(1, 0, 5'd0, 32'd0, 32'd0, 1, 5'd12, 32'hC9, 32'h990, 5'd10, 5'd11);
        idle(5'd10, 5'd11);
        idle(5'd10, 5'd11);
        idle(5'd12, 5'd0);

        // Randomized traffic with shifting pipeline load.
        pct = 50;
        for (int i = 0; i < 3000; i++) begin
            if (i % 40 == 0) pct = $urandom_range(0, 3) * 30 + 5;
            pwe = ($urandom_range(0, 99) < pct);
            if (m_stall() && $urandom_range(0, 1) == 1) pwe = 1'b0;
            cyc($urandom_range(0, 399) == 0,
                pwe, 5'($urandom_range(0, 7)), $urandom, $urandom,
                $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom, $urandom,
                5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end

        for (int i = 0; i < 10; i++) idle(5'd1, 5'd2);
        @(posedge clk);
        #2;
        chk("scoreboard_drained", 64'(expq.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/grf_wb_arbiter.md
Name: grf_wb_arbiter

Overview:
- Shares the register file's single write port between two writers: the main pipeline write-back stage and an auxiliary long-latency unit (multiply/divide result or similar).
- The pipeline has strict priority. Auxiliary writes are buffered in a small in-order queue and drained into idle write-port cycles.
- Provides pending-write lookups for hazard stalls and a starvation stall request so that queued writes always retire.
- Sits between write-back and the register file write inputs, whose write port is write-enable, address, data and PC.

Parameters:
- DEPTH, 2: auxiliary queue entries; power of two, at least 2.
- MAX_WAIT, 4: number of consecutive blocked cycles of a non-empty queue head before stall_req asserts.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- pipe_we  in  1  pipeline write request this cycle
- pipe_a3  in  5  pipeline destination register
- pipe_wd  in  32  pipeline write data
- pipe_pc  in  32  PC of the pipeline writer
- aux_valid  in  1  auxiliary write offered
- aux_ready  out  1  queue can accept; equals "queue not full"
- aux_a3  in  5  auxiliary destination register
- aux_wd  in  32  auxiliary write data
- aux_pc  in  32  PC of the auxiliary writer
- grf_we  out  1  register-file write enable (registered)
- grf_a3  out  5  register-file write address (registered)
- grf_wd  out  32  register-file write data (registered)
- grf_pc  out  32  PC forwarded for write logging (registered)
- q1_a, q2_a  in  5 each  hazard query addresses
- q1_busy, q2_busy  out  1 each  query register has a write pending
- stall_req  out  1  upstream must hold off pipe_we next cycle

Behaviour:
- Reset: synchronous, active-high, on clk rising edge. Effects:
  - queue emptied and all entries invalidated
  - wait counter cleared
  - grf_we, grf_a3, grf_wd, grf_pc all 0
  - aux_ready becomes 1; stall_req, q1_busy and q2_busy become 0
  - any in-flight auxiliary data is discarded, including when reset lands mid-drain
- Output register: one-cycle latency. Inputs sampled at an edge appear on the grf_* outputs after that edge. If nothing is selected, grf_we=0 and the other grf_* outputs hold their previous values.
- Selection each cycle, in this order:
  1. pipe_we=1 and pipe_a3!=0 → pipeline write goes out.
  2. pipe_we=1 and pipe_a3=0 → nothing is written, but the slot is still consumed; the queue does not drain.
  3. Otherwise, queue non-empty → pop the head. If the head is live and its a3!=0, it goes out with grf_we=1. A killed head, or one with a3=0, pops with grf_we=0.
- Enqueue:
  - An entry is accepted when aux_valid && aux_ready at the edge.
  - A push and a pop in the same cycle are both allowed; when the queue is full, aux_ready=0 even if a pop occurs that cycle.
  - An auxiliary write always passes through the queue, so its minimum latency is 2 edges from acceptance to grf_we.
  - Order is FIFO; pointers wrap modulo DEPTH; the count ranges 0..DEPTH.
- Write-after-write:
  - A selected pipeline write with a3=X kills every queued live entry with a3=X that was already stored before the edge.
  - An auxiliary entry accepted at the same edge is younger and stays live.
  - Killed entries still occupy a slot until popped.
- Busy lookup (combinational): qN_busy=1 when qN_a!=0 and qN_a matches a live queued entry, or matches grf_a3 while grf_we=1.
- Starvation:
  - The wait counter increments on each edge where the queue is non-empty and the head is not popped.
  - It clears on a pop, or when the queue is empty.
  - stall_req = (counter >= MAX_WAIT) and queue non-empty.
  - If pipe_we is nonetheless asserted, the pipeline still wins and the counter saturates at MAX_WAIT.

Test Plan:
- Reset, then aux_valid=1 with a3=5, wd=0x1234, pipe idle → entry accepted at edge 1; grf_we=1, grf_a3=5, grf_wd=0x1234 after edge 2; aux_ready stays 1.
- pipe_we=1 on a3=3 continuously; push aux entries with a3=7 and a3=8 → aux_ready=0 after 2 accepts. stall_req=1 once the head has been blocked for 4 edges. After pipe_we drops, a3=7 writes on the next edge and a3=8 on the edge after.
- Queue holds a3=9 (wd=0xAA); pipe writes a3=9 (wd=0xBB) → grf writes 0xBB; the queued entry later pops with grf_we=0; q1_a=9 reads busy=1 before the kill and busy=0 after the pop.
- Same edge: pipe write a3=4 and aux accept a3=4 → the pipeline write goes out first; the aux entry stays live and writes next idle cycle.
- aux a3=0 and pipe a3=0 requests → grf_we never asserts; q1_a=0 always reads busy=0.
- Reset asserted with 2 entries queued and stall_req=1 → next cycle: queue empty, all outputs 0, aux_ready=1; the queued data is never written.
